// File: rtl/sdram_client_port.sv
// Client-side request/response port for an SDRAM controller: packs requests into
// writer-FIFO command words and returns read data in order from the reader FIFO.
module sdram_client_port #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [23:0] req_addr_i,
    input  logic [15:0] req_data_i,
    output logic [59:0] writer_d_o,
    output logic        writer_enq_o,
    input  logic        writer_full_i,
    input  logic [15:0] reader_q_i,
    output logic        reader_deq_o,
    input  logic        reader_empty_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [15:0] rsp_data_o,
    output logic [3:0]  outstanding_o
);

    typedef enum logic [1:0] {
        R_IDLE,
        R_DEQ,
        R_CAP,
        R_HOLD
    } rstate_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    rstate_t     state_reg, state_next;
    logic [59:0] writer_d_reg;
    logic        writer_enq_reg;
    logic        rsp_valid_reg, rsp_valid_next;
    logic [15:0] rsp_data_reg, rsp_data_next;
    logic [3:0]  outstanding_reg, outstanding_next;
    logic        accept;
    logic        rd_accept;
    logic        cap;
    logic        deq;

    // Blocking on the previous enqueue hides the one-cycle lag of writer_full_i.
    assign req_ready_o = !writer_full_i && !writer_enq_reg
                         && (req_we_i || (outstanding_reg < MAX_CNT));
    assign accept      = req_valid_i && req_ready_o;
    assign rd_accept   = accept && !req_we_i;

    always_comb begin
        state_next       = state_reg;
        rsp_valid_next   = rsp_valid_reg;
        rsp_data_next    = rsp_data_reg;
        outstanding_next = outstanding_reg;
        deq              = 1'b0;
        cap              = 1'b0;
        case (state_reg)
            R_IDLE: begin
                // Data arriving with nothing outstanding is spurious and left in the FIFO.
                if (!reader_empty_i && (outstanding_reg != 4'd0)) begin
                    deq        = 1'b1;
                    state_next = R_DEQ;
                end
            end
            R_DEQ: state_next = R_CAP;
            R_CAP: begin
                cap            = 1'b1;
                rsp_data_next  = reader_q_i;
                rsp_valid_next = 1'b1;
                state_next     = R_HOLD;
            end
            R_HOLD: begin
                if (rsp_ready_i) begin
                    rsp_valid_next = 1'b0;
                    state_next     = R_IDLE;
                end
            end
            default: state_next = R_IDLE;
        endcase
        case ({rd_accept, cap})
            2'b10:   outstanding_next = outstanding_reg + 4'd1;
            2'b01:   outstanding_next = outstanding_reg - 4'd1;
            default: outstanding_next = outstanding_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg       <= R_IDLE;
            writer_d_reg    <= '0;
            writer_enq_reg  <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_data_reg    <= '0;
            outstanding_reg <= '0;
        end else begin
            state_reg       <= state_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_data_reg    <= rsp_data_next;
            outstanding_reg <= outstanding_next;
            writer_enq_reg  <= accept;
            if (accept) begin
                writer_d_reg <= {19'd0, req_we_i, req_addr_i, (req_we_i ? req_data_i : 16'h0)};
            end
        end
    end

    assign writer_d_o    = writer_d_reg;
    assign writer_enq_o  = writer_enq_reg;
    assign reader_deq_o  = deq;
    assign rsp_valid_o   = rsp_valid_reg;
    assign rsp_data_o    = rsp_data_reg;
    assign outstanding_o = outstanding_reg;

endmodule

// File: tb/tb_sdram_client_port.sv
// Bench for sdram_client_port: a controller model returns addr[15:0] for each read,
// and a transaction-level scoreboard checks commands, responses and counts.
module tb_sdram_client_port;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic        req_valid_i, req_ready_o, req_we_i;
    logic [23:0] req_addr_i;
    logic [15:0] req_data_i;
    logic [59:0] writer_d_o;
    logic        writer_enq_o, writer_full_i;
    logic [15:0] reader_q_i;
    logic        reader_deq_o, reader_empty_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [15:0] rsp_data_o;
    logic [3:0]  outstanding_o;

    sdram_client_port #(.MAX_OUTSTANDING(MAX)) dut (
        .clk(clk), .reset_n_i(reset_n_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .writer_d_o(writer_d_o), .writer_enq_o(writer_enq_o), .writer_full_i(writer_full_i),
        .reader_q_i(reader_q_i), .reader_deq_o(reader_deq_o), .reader_empty_i(reader_empty_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .outstanding_o(outstanding_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;

    // scoreboard state
    logic [59:0] exp_cmd[$];
    logic [15:0] exp_rsp[$];
    int          outst_m, cyc, rises, deq_count, enq_total, fall_cyc, lat_last, txn;
    logic        acc_last, vprev, empty_prev;
    logic [15:0] held;
    // controller model state
    logic [15:0] rd_fifo[$];
    logic [15:0] pend_data[$];
    int          pend_due[$];
    logic [15:0] reader_q_m;
    logic        deq_seen, enq_seen, ret_hold;
    logic [59:0] cmd_seen;
    int          lat_max;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic reset_model();
        exp_cmd.delete(); exp_rsp.delete(); rd_fifo.delete();
        pend_data.delete(); pend_due.delete();
        outst_m = 0; acc_last = 0; vprev = 0; empty_prev = 1;
        deq_seen = 0; enq_seen = 0; cmd_seen = '0; reader_q_m = '0;
    endtask

    task automatic monitor();
        logic ready_exp;
        cyc++;
        deq_seen = reader_deq_o; enq_seen = writer_enq_o; cmd_seen = writer_d_o;
        deq_count += int'(reader_deq_o);
        if (!reader_empty_i && empty_prev) fall_cyc = cyc;
        empty_prev = reader_empty_i;
        if (rsp_valid_o && !vprev) begin
            rises++;
            lat_last = cyc - fall_cyc;
            outst_m--;
            if (exp_rsp.size() == 0) check("rsp_unexpected", 64'(1), 64'(0));
            else check("rsp_data", 64'(rsp_data_o), 64'(exp_rsp.pop_front()));
            held = rsp_data_o;
            $display("rsp  data=%04h", rsp_data_o);
        end else if (rsp_valid_o) begin
            check("rsp_stable", 64'(rsp_data_o), 64'(held));
        end
        vprev = rsp_valid_o;
        check("outstanding", 64'(outstanding_o), 64'(outst_m));
        check("enq_pulse", 64'(writer_enq_o), 64'(acc_last));
        if (writer_enq_o) begin
            enq_total++;
            if (exp_cmd.size() == 0) check("cmd_unexpected", 64'(1), 64'(0));
            else check("cmd_word", 64'(writer_d_o), 64'(exp_cmd.pop_front()));
        end
        check("deq_while_valid", 64'(reader_deq_o && rsp_valid_o), 64'(0));
        check("deq_spurious", 64'(reader_deq_o && outst_m == 0), 64'(0));
        ready_exp = !writer_full_i && !acc_last && (req_we_i || outst_m < MAX);
        check("req_ready", 64'(req_ready_o), 64'(ready_exp));
        acc_last = req_valid_i && req_ready_o;
        if (acc_last) begin
            txn++;
            exp_cmd.push_back({19'd0, req_we_i, req_addr_i, (req_we_i ? req_data_i : 16'h0)});
            if (!req_we_i) begin
                exp_rsp.push_back(req_addr_i[15:0]);
                outst_m++;
            end
            $display("txn %0d %s addr=%06h data=%04h", txn, req_we_i ? "WR" : "RD",
                     req_addr_i, req_data_i);
        end
    endtask

    task automatic env_update();
        if (deq_seen && rd_fifo.size() > 0) reader_q_m = rd_fifo.pop_front();
        if (enq_seen && !cmd_seen[40]) begin
            pend_data.push_back(cmd_seen[31:16]);
            pend_due.push_back(cyc + int'($urandom_range(lat_max, 0)));
        end
        while (!ret_hold && pend_data.size() > 0 && pend_due[0] <= cyc) begin
            rd_fifo.push_back(pend_data.pop_front());
            void'(pend_due.pop_front());
        end
    endtask

    task automatic step();
        @(negedge clk); monitor();
        @(posedge clk); env_update();
        #1;
        reader_empty_i = (rd_fifo.size() == 0);
        reader_q_i     = reader_q_m;
    endtask

    task automatic issue(input logic we, input logic [23:0] a, input logic [15:0] d);
        logic ok = 0;
        req_valid_i = 1; req_we_i = we; req_addr_i = a; req_data_i = d;
        for (int i = 0; i < 30 && !ok; i++) begin
            step();
            ok = acc_last;
        end
        check("issue_accepted", 64'(ok), 64'(1));
        req_valid_i = 0;
    endtask

    task automatic wait_rise(input int target);
        for (int i = 0; i < 40 && rises < target; i++) step();
        check("rsp_arrived", 64'(rises >= target), 64'(1));
    endtask

    task automatic drain();
        logic done = 0;
        req_valid_i = 0; rsp_ready_i = 1; writer_full_i = 0; ret_hold = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            step();
            done = (outstanding_o == 0) && (exp_rsp.size() == 0) && (rd_fifo.size() == 0)
                   && !rsp_valid_o && (exp_cmd.size() == 0);
        end
        check("drained", 64'(done), 64'(1));
    endtask

    initial begin
        int r0, d0, e0, n_acc;
        logic got;
        reset_n_i = 0; req_valid_i = 0; req_we_i = 0; req_addr_i = '0; req_data_i = '0;
        writer_full_i = 0; reader_empty_i = 1; reader_q_i = '0; rsp_ready_i = 1;
        ret_hold = 0; lat_max = 0; cyc = 0; rises = 0; deq_count = 0; enq_total = 0;
        fall_cyc = 0; lat_last = 0; txn = 0; held = '0;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check("rst_enq", 64'(writer_enq_o), 64'(0));
        check("rst_d", 64'(writer_d_o), 64'(0));
        check("rst_deq", 64'(reader_deq_o), 64'(0));
        check("rst_valid", 64'(rsp_valid_o), 64'(0));
        check("rst_rdata", 64'(rsp_data_o), 64'(0));
        check("rst_outst", 64'(outstanding_o), 64'(0));
        @(negedge clk) reset_n_i = 1;
        @(posedge clk); #1;

        // single write
        issue(1'b1, 24'h1000, 16'h1000);
        check("wr_enq", 64'(writer_enq_o), 64'(1));
        check("wr_word", 64'(writer_d_o), 64'({19'd0, 1'b1, 24'h1000, 16'h1000}));
        step();
        check("wr_enq_drop", 64'(writer_enq_o), 64'(0));
        check("wr_word_held", 64'(writer_d_o), 64'({19'd0, 1'b1, 24'h1000, 16'h1000}));
        check("wr_outst", 64'(outstanding_o), 64'(0));

        // single read, minimum latency
        r0 = rises; d0 = deq_count;
        issue(1'b0, 24'h1000, 16'hBEEF);
        check("rd_word", 64'(writer_d_o), 64'({19'd0, 1'b0, 24'h1000, 16'h0}));
        check("rd_outst_inc", 64'(outstanding_o), 64'(1));
        wait_rise(r0 + 1);
        check("rd_data", 64'(rsp_data_o), 64'(16'h1000));
        check("rd_latency", 64'(lat_last), 64'(3));
        check("rd_one_deq", 64'(deq_count - d0), 64'(1));
        check("rd_outst_dec", 64'(outstanding_o), 64'(0));
        drain();

        // writer full for 5 cycles
        writer_full_i = 1; req_valid_i = 1; req_we_i = 1;
        req_addr_i = 24'($urandom); req_data_i = 16'($urandom);
        e0 = enq_total;
        for (int i = 0; i < 5; i++) begin
            step();
            check("full_stall", 64'(req_ready_o), 64'(0));
        end
        writer_full_i = 0;
        step();
        check("full_no_enq", 64'(enq_total - e0), 64'(0));
        check("enq_after_full", 64'(writer_enq_o), 64'(1));
        req_valid_i = 0;
        drain();

        // outstanding limit: 5 reads, no returns
        ret_hold = 1; req_valid_i = 1; req_we_i = 0; req_addr_i = 24'($urandom); n_acc = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (acc_last) begin n_acc++; req_addr_i = 24'($urandom); end
        end
        check("limit_accepted", 64'(n_acc), 64'(MAX));
        check("limit_outst", 64'(outstanding_o), 64'(MAX));
        check("limit_stall", 64'(req_ready_o), 64'(0));
        req_we_i = 1; req_data_i = 16'($urandom);
        step();
        check("limit_write_ok", 64'(acc_last), 64'(1));
        req_we_i = 0; req_addr_i = 24'($urandom);
        r0 = rises; ret_hold = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (acc_last) begin got = 1; check("fifth_after_rsp", 64'(rises > r0), 64'(1)); end
        end
        check("fifth_accepted", 64'(got), 64'(1));
        drain();

        // response backpressure with two words queued
        rsp_ready_i = 0; ret_hold = 1;
        issue(1'b0, 24'($urandom), 16'h0);
        issue(1'b0, 24'($urandom), 16'h0);
        r0 = rises; ret_hold = 0;
        wait_rise(r0 + 1);
        d0 = deq_count;
        repeat (10) step();
        check("bp_no_deq", 64'(deq_count - d0), 64'(0));
        check("bp_valid_held", 64'(rsp_valid_o), 64'(1));
        rsp_ready_i = 1;
        wait_rise(r0 + 2);
        drain();

        // spurious data with nothing outstanding
        rd_fifo.push_back(16'hDEAD); reader_empty_i = 0; d0 = deq_count;
        repeat (5) step();
        check("spurious_no_deq", 64'(deq_count - d0), 64'(0));
        rd_fifo.delete(); reader_empty_i = 1;

        // asynchronous reset while holding a response
        rsp_ready_i = 0; r0 = rises;
        issue(1'b0, 24'($urandom), 16'h0);
        wait_rise(r0 + 1);
        step();
        reset_n_i = 0;
        #1;
        check("arst_valid", 64'(rsp_valid_o), 64'(0));
        check("arst_outst", 64'(outstanding_o), 64'(0));
        check("arst_rdata", 64'(rsp_data_o), 64'(0));
        reset_model();
        @(posedge clk);
        @(negedge clk) reset_n_i = 1;
        @(posedge clk); #1;
        reader_empty_i = 1; reader_q_i = '0; rsp_ready_i = 1;
        drain();

        // randomized traffic
        lat_max = 5;
        for (int i = 0; i < 600; i++) begin
            req_valid_i   = ($urandom_range(2, 0) != 0);
            req_we_i      = 1'($urandom);
            req_addr_i    = 24'($urandom);
            req_data_i    = 16'($urandom);
            rsp_ready_i   = ($urandom_range(3, 0) != 0);
            writer_full_i = ($urandom_range(5, 0) == 0);
            step();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sdram_client_port.md
SDRAM_CLIENT_PORT -- requirements
Module: sdram_client_port

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of read commands issued but not yet returned (range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-003 SHALL have port reset_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid_i, input, 1 bit: client request valid.
REQ-005 SHALL have port req_ready_o, output, 1 bit: request accepted this cycle when high together with req_valid_i.
REQ-006 SHALL have port req_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port req_addr_i, input, 24 bits: word address.
REQ-008 SHALL have port req_data_i, input, 16 bits: write data (ignored for reads).
REQ-009 SHALL have port writer_d_o, output, 60 bits: command word to the controller writer FIFO.
REQ-010 SHALL have port writer_enq_o, output, 1 bit: writer FIFO enqueue strobe.
REQ-011 SHALL have port writer_full_i, input, 1 bit: writer FIFO full flag.
REQ-012 SHALL have port reader_q_i, input, 16 bits: controller read data.
REQ-013 SHALL have port reader_deq_o, output, 1 bit: reader FIFO dequeue strobe.
REQ-014 SHALL have port reader_empty_i, input, 1 bit: reader FIFO empty flag.
REQ-015 SHALL have port rsp_valid_o, output, 1 bit: read response valid.
REQ-016 SHALL have port rsp_ready_i, input, 1 bit: client accepts the response.
REQ-017 SHALL have port rsp_data_o, output, 16 bits: read response data.
REQ-018 SHALL have port outstanding_o, output, 4 bits: current count of outstanding reads.

Function
REQ-019 Command format SHALL be: [59:41] = 0, [40] = req_we_i, [39:16] = req_addr_i, [15:0] = req_data_i for writes and 0 for reads.
REQ-020 req_ready_o SHALL be combinational: !writer_full_i && !writer_enq_o && (req_we_i || outstanding < MAX_OUTSTANDING).
- Enqueues are therefore at most every other cycle, which tolerates the one-cycle lag of the full flag.
REQ-021 On accept, writer_d_o and writer_enq_o SHALL be registered; writer_enq_o is high for exactly 1 cycle and writer_d_o is held until the next accept.
REQ-022 An accepted read SHALL increment outstanding at the same edge that writer_enq_o is asserted; writes SHALL NOT change outstanding.
REQ-023 The read-return FSM SHALL have the states R_IDLE, R_DEQ, R_CAP and R_HOLD:
- R_IDLE -> R_DEQ when !reader_empty_i && outstanding != 0, asserting reader_deq_o for 1 cycle.
- R_DEQ -> R_CAP unconditionally, with reader_deq_o low.
- R_CAP: capture reader_q_i into rsp_data_o, set rsp_valid_o, decrement outstanding, go to R_HOLD.
- R_HOLD: hold rsp_valid_o and rsp_data_o stable until rsp_ready_i, then clear rsp_valid_o and go to R_IDLE.
REQ-024 Simultaneous accepted read and R_CAP decrement in the same cycle SHALL leave outstanding unchanged.
REQ-025 When !reader_empty_i and outstanding == 0 (spurious data), the block SHALL NOT dequeue.
REQ-026 Responses SHALL return in request order, one word per read, with minimum latency of 3 cycles from reader_empty_i falling to rsp_valid_o rising.
REQ-027 When outstanding == MAX_OUTSTANDING, read requests SHALL stall (req_ready_o low), while write requests still proceed.

Reset
REQ-028 On reset_n_i low, the block SHALL asynchronously clear writer_enq_o, reader_deq_o, rsp_valid_o and outstanding_o, set writer_d_o and rsp_data_o to 0, and put the FSM in R_IDLE.
REQ-029 Reset mid-transaction SHALL discard any in-flight response and outstanding count; there are no outputs during reset other than these reset values.

Verification
REQ-030 Write addr 24'h1000 with data 16'h1000 -> one-cycle writer_enq_o with writer_d_o = {19'd0, 1'b1, 24'h1000, 16'h1000}; outstanding stays 0.
REQ-031 Read addr 24'h1000, model returns 16'h1000 -> writer_d_o = {19'd0, 1'b0, 24'h1000, 16'h0}, one reader_deq_o pulse, rsp_data_o = 16'h1000, outstanding 1 -> 0.
REQ-032 Back-to-back requests with writer_full_i held high for 5 cycles -> req_ready_o low throughout, no enqueue; first enqueue on the cycle after full drops.
REQ-033 Issue 5 reads with MAX_OUTSTANDING = 4 and no returns -> 4 enqueued, 5th stalled; after one response is consumed, the 5th is accepted.
REQ-034 Hold rsp_ready_i low for 10 cycles with 2 words in the reader FIFO -> first word held stable, no second dequeue until handshake; words delivered in order.
REQ-035 Assert reset_n_i low during R_HOLD -> rsp_valid_o and outstanding_o are 0 immediately, without waiting for a clock edge.
